register_file_status: RTL and testbench

//   Architectural state feeding the datapath ALU: 32 x 64-bit LEGv8 register file with two

---
 rtl/register_file_status_if.sv | 26 ++
 rtl/register_file_status.sv | 65 ++++++
 tb/tb_register_file_status.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/register_file_status_if.sv
// rtl/register_file_status_if.sv - read/write/status signal bundle between decode/writeback, ALU and register file
interface register_file_status_if #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 5
);
  logic [SEL_BITS-1:0] read_sel_a;
  logic [SEL_BITS-1:0] read_sel_b;
  logic [WIDTH-1:0]    data_a;
  logic [WIDTH-1:0]    data_b;
  logic                write_en;
  logic [SEL_BITS-1:0] write_sel;
  logic [WIDTH-1:0]    write_data;
  logic                status_load;
  logic [3:0]          status_in;
  logic [3:0]          status_out;

  modport master (
    output read_sel_a, read_sel_b, write_en, write_sel, write_data, status_load, status_in,
    input  data_a, data_b, status_out
  );

  modport slave (
    input  read_sel_a, read_sel_b, write_en, write_sel, write_data, status_load, status_in,
    output data_a, data_b, status_out
  );
endinterface

// File: rtl/register_file_status.sv
// rtl/register_file_status.sv - LEGv8 register file (XZR hardwired zero) plus NZCV status register
// Optional REGFILE_BYPASS_EN: forward write_data to a read port selecting the register being written.
module register_file_status #(
  parameter int WIDTH    = 64,
  parameter int SEL_BITS = 5,
  parameter int ZERO_REG = 31
) (
  input logic                    clock,
  input logic                    reset,
  register_file_status_if.slave  rf
);
  localparam int NUM_REGS = 2 ** SEL_BITS;
  localparam logic [SEL_BITS-1:0] ZERO_SEL = SEL_BITS'(ZERO_REG);

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [3:0]       status_q;
  logic [3:0]       status_d;

  always_comb begin
    regs_d = regs_q;
    if (rf.write_en && (rf.write_sel != ZERO_SEL)) begin
      regs_d[rf.write_sel] = rf.write_data;
    end
    // XZR entry is held constant so synthesis drops its storage
    regs_d[ZERO_SEL] = '0;
    status_d = rf.status_load ? rf.status_in : status_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      status_q <= '0;
    end else begin
      regs_q   <= regs_d;
      status_q <= status_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [SEL_BITS-1:0] sel);
    logic [WIDTH-1:0] val;
    if (sel == ZERO_SEL) begin
      val = '0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      if (rf.write_en && (rf.write_sel == sel)) begin
        val = rf.write_data;
      end else begin
        val = regs_q[sel];
      end
`else
      val = regs_q[sel];
`endif
    end
    return val;
  endfunction

  always_comb begin
    rf.data_a     = read_port(rf.read_sel_a);
    rf.data_b     = read_port(rf.read_sel_b);
    rf.status_out = status_q;
  end
endmodule

// File: tb/tb_register_file_status.sv
// tb/tb_register_file_status.sv - directed vector bench for register_file_status
module tb_register_file_status;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  register_file_status_if #(.WIDTH(64), .SEL_BITS(5)) rf ();

  register_file_status #(.WIDTH(64), .SEL_BITS(5), .ZERO_REG(31)) dut (
    .clock (clk),
    .reset (rst),
    .rf    (rf.slave)
  );

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wsel;
    logic [63:0] wdata;
    logic        sl;
    logic [3:0]  sin;
    logic [4:0]  sel_a;
    logic [4:0]  sel_b;
    logic [63:0] exp_a;
    logic [63:0] exp_b;
    logic [3:0]  exp_st;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle();
    rf.write_en    = 1'b0;
    rf.write_sel   = 5'd0;
    rf.write_data  = 64'd0;
    rf.status_load = 1'b0;
    rf.status_in   = 4'd0;
    rst            = 1'b0;
  endtask

  initial begin
    // rst we wsel wdata sl sin sel_a sel_b exp_a exp_b exp_st
    vecs[0]  = '{1'b1, 1'b0, 5'd0,  64'd0,                  1'b0, 4'b0000, 5'd0,  5'd31, 64'd0,                  64'd0,                  4'b0000};
    vecs[1]  = '{1'b0, 1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 1'b0, 4'b0000, 5'd3,  5'd3,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 4'b0000};
    vecs[2]  = '{1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0000, 5'd31, 5'd31, 64'd0,                  64'd0,                  4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 5'd5,  64'hDEAD,               1'b1, 4'b0110, 5'd5,  5'd3,  64'hDEAD,               64'h0123_4567_89AB_CDEF, 4'b0110};
    vecs[4]  = '{1'b0, 1'b0, 5'd0,  64'd0,                  1'b0, 4'b1001, 5'd5,  5'd5,  64'hDEAD,               64'hDEAD,               4'b0110};
    vecs[5]  = '{1'b1, 1'b0, 5'd0,  64'd0,                  1'b0, 4'b0000, 5'd5,  5'd3,  64'd0,                  64'd0,                  4'b0000};
    vecs[6]  = '{1'b1, 1'b1, 5'd2,  64'h9,                  1'b1, 4'b1111, 5'd2,  5'd2,  64'd0,                  64'd0,                  4'b0000};
    vecs[7]  = '{1'b0, 1'b1, 5'd2,  64'h9,                  1'b1, 4'b1001, 5'd2,  5'd31, 64'h9,                  64'd0,                  4'b1001};
    vecs[8]  = '{1'b0, 1'b1, 5'd0,  64'hAAAA_5555_AAAA_5555, 1'b0, 4'b0000, 5'd0,  5'd2,  64'hAAAA_5555_AAAA_5555, 64'h9,                  4'b1001};
    vecs[9]  = '{1'b0, 1'b1, 5'd30, 64'h8000_0000_0000_0001, 1'b0, 4'b0000, 5'd30, 5'd0,  64'h8000_0000_0000_0001, 64'hAAAA_5555_AAAA_5555, 4'b1001};
    vecs[10] = '{1'b0, 1'b0, 5'd30, 64'd0,                  1'b0, 4'b0000, 5'd30, 5'd30, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 4'b1001};
    vecs[11] = '{1'b0, 1'b0, 5'd0,  64'd0,                  1'b1, 4'b1000, 5'd1,  5'd0,  64'd0,                  64'hAAAA_5555_AAAA_5555, 4'b1000};

    idle();
    rf.read_sel_a = 5'd0;
    rf.read_sel_b = 5'd0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst            = vecs[i].rst;
      rf.write_en    = vecs[i].we;
      rf.write_sel   = vecs[i].wsel;
      rf.write_data  = vecs[i].wdata;
      rf.status_load = vecs[i].sl;
      rf.status_in   = vecs[i].sin;
      @(posedge clk);
      #1;
      idle();
      rf.read_sel_a = vecs[i].sel_a;
      rf.read_sel_b = vecs[i].sel_b;
      #1;
      check($sformatf("vec%0d_data_a", i), rf.data_a, vecs[i].exp_a);
      check($sformatf("vec%0d_data_b", i), rf.data_b, vecs[i].exp_b);
      check($sformatf("vec%0d_status", i), {60'd0, rf.status_out}, {60'd0, vecs[i].exp_st});
    end

    // Same-cycle write/read of X7: forwarded only in the bypass build
    @(negedge clk);
    rf.write_en = 1'b1; rf.write_sel = 5'd7; rf.write_data = 64'h11;
    @(posedge clk);
    #1;
    idle();
    rf.read_sel_a = 5'd7;
    rf.read_sel_b = 5'd7;
    #1;
    check("x7_initial", rf.data_a, 64'h11);
    @(negedge clk);
    rf.write_en = 1'b1; rf.write_sel = 5'd7; rf.write_data = 64'h55;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x7_pre_edge_a", rf.data_a, 64'h55);
    check("x7_pre_edge_b", rf.data_b, 64'h55);
`else
    check("x7_pre_edge_a", rf.data_a, 64'h11);
    check("x7_pre_edge_b", rf.data_b, 64'h11);
`endif
    @(posedge clk);
    #1;
    idle();
    #1;
    check("x7_post_edge_a", rf.data_a, 64'h55);
    check("x7_post_edge_b", rf.data_b, 64'h55);

    // XZR write while reading it in the same cycle never forwards
    @(negedge clk);
    rf.read_sel_a = 5'd31;
    rf.read_sel_b = 5'd7;
    rf.write_en = 1'b1; rf.write_sel = 5'd31; rf.write_data = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    check("xzr_pre_edge", rf.data_a, 64'd0);
    check("x7_unaffected", rf.data_b, 64'h55);
    @(posedge clk);
    #1;
    idle();
    #1;
    check("xzr_post_edge", rf.data_a, 64'd0);

    // Reset alongside a write: stored value clears, bypass build still forwards before the edge
    @(negedge clk);
    rst = 1'b1;
    rf.read_sel_a = 5'd7;
    rf.write_en = 1'b1; rf.write_sel = 5'd7; rf.write_data = 64'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rst_bypass_pre_edge", rf.data_a, 64'h77);
`else
    check("rst_bypass_pre_edge", rf.data_a, 64'h55);
`endif
    @(posedge clk);
    #1;
    idle();
    #1;
    check("rst_write_post_edge", rf.data_a, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
